// File: rtl/hamming_scrubber_pkg.sv
// hamming_scrub_pkg: shared types and helpers for the Hamming RAM scrubber.
//   scrub_state_t      : scrub FSM state encoding
//   hamming_nk_legal() : true for the supported (N,K) code pairings (7,4) and (15,11)
package hamming_scrub_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    RD   = 3'd2,
    CHK  = 3'd3,
    WB   = 3'd4
  } scrub_state_t;

  function automatic bit hamming_nk_legal(input int n, input int k);
    return ((n == 15) && (k == 11)) || ((n == 7) && (k == 4));
  endfunction

endpackage

// File: rtl/hamming_scrubber_h3_correct_n_k.sv
// h3_correct_n_k: single-error-correcting Hamming decoder, purely combinational.
// Codeword bit i sits at Hamming position i+1; parity bits occupy the
// power-of-two positions, so the syndrome is the XOR of the positions of all
// set bits and, when non-zero, names the position to flip.
//   code_word : N-bit received word
//   corr_word : N-bit corrected word (equals code_word when syndrome is 0)
//   sec       : 1 when a correction was applied
module h3_correct_n_k #(
  parameter int N = 15,
  parameter int K = 11
) (
  input  logic [N-1:0] code_word,
  output logic [N-1:0] corr_word,
  output logic         sec
);

  localparam int R = N - K;

  logic [R-1:0] syndrome;

  always_comb begin
    syndrome = '0;
    for (int unsigned p = 0; p < N; p++) begin
      if (code_word[p]) syndrome ^= R'(p + 1);
    end
    sec = (syndrome != '0);
    for (int unsigned p = 0; p < N; p++) begin
      corr_word[p] = code_word[p] ^ (syndrome == R'(p + 1));
    end
  end

endmodule

// File: rtl/hamming_scrubber.sv
// hamming_scrubber: background scrub controller for a single-port Hamming RAM.
// Walks every address, reads and corrects each word, and writes back only words
// that had a single-bit error. The user requester always owns the RAM port.
// Optional macro HAMMING_SCRUB_LOG_EN adds last_err_addr_o / last_err_valid_o.
// Ports:
//   clk_i, rst_i (sync, active-high), enable_i (level), clear_i (count clear)
//   usr_req_i/usr_we_i/usr_addr_i/usr_wdata_i : user access request
//   usr_gnt_o, usr_rvalid_o, usr_rdata_o       : user grant / read return
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o   : RAM port, mem_rdata_i 1-cycle latency
//   scrub_addr_o, pass_done_o, sec_count_o     : scrub progress and corrected-error count
module hamming_scrubber
  import hamming_scrub_pkg::*;
#(
  parameter int N              = 15,
  parameter int K              = 11,
  parameter int DEPTH          = 256,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 16,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             usr_req_i,
  input  logic             usr_we_i,
  input  logic [AW-1:0]    usr_addr_i,
  input  logic [N-1:0]     usr_wdata_i,
  output logic             usr_gnt_o,
  output logic             usr_rvalid_o,
  output logic [N-1:0]     usr_rdata_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [N-1:0]     mem_wdata_o,
  input  logic [N-1:0]     mem_rdata_i,
  output logic [AW-1:0]    scrub_addr_o,
  output logic             pass_done_o,
`ifdef HAMMING_SCRUB_LOG_EN
  output logic [AW-1:0]    last_err_addr_o,
  output logic             last_err_valid_o,
`endif
  output logic [CNT_W-1:0] sec_count_o
);

  localparam int IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  if (!hamming_nk_legal(N, K)) begin : g_illegal_n_k
    $error("hamming_scrubber: unsupported (N,K) pairing");
  end

  scrub_state_t     state_q;
  logic [IW-1:0]    cnt_q;
  logic [AW-1:0]    scrub_addr_q;
  logic [N-1:0]     corr_q;
  logic             pass_done_q;
  logic             rvalid_q;
  logic [CNT_W-1:0] sec_count_q;

  logic [N-1:0]     corr_word;
  logic             sec;
  logic             collision;
  logic             fsm_rd;
  logic             fsm_wr;
  logic             advance;

  h3_correct_n_k #(.N(N), .K(K)) u_correct (
    .code_word (mem_rdata_i),
    .corr_word (corr_word),
    .sec       (sec)
  );

  assign collision = usr_req_i & usr_we_i & (usr_addr_i == scrub_addr_q);
  assign fsm_rd    = (state_q == RD) & enable_i & ~usr_req_i;
  assign fsm_wr    = (state_q == WB) & ~usr_req_i;
  // A colliding user write in CHK or WB drops the write-back but still moves on.
  assign advance   = ((state_q == CHK) & (~sec | collision)) |
                     ((state_q == WB) & (collision | ~usr_req_i));

  // RAM port: user first, then the FSM. Everything is held off while rst_i is
  // high so a reset landing in WB never lets the write-back through.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = scrub_addr_q;
    mem_wdata_o = corr_q;
    if (!rst_i) begin
      if (usr_req_i) begin
        mem_en_o    = 1'b1;
        mem_we_o    = usr_we_i;
        mem_addr_o  = usr_addr_i;
        mem_wdata_o = usr_wdata_i;
      end else if (fsm_rd) begin
        mem_en_o = 1'b1;
      end else if (fsm_wr) begin
        mem_en_o = 1'b1;
        mem_we_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      scrub_addr_q <= '0;
      corr_q       <= '0;
      pass_done_q  <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      rvalid_q    <= usr_req_i & ~usr_we_i;
      pass_done_q <= 1'b0;
      if (state_q == CHK) corr_q <= corr_word;
      if (advance) begin
        scrub_addr_q <= scrub_addr_q + 1'b1;
        pass_done_q  <= (scrub_addr_q == AW'(DEPTH - 1));
        cnt_q        <= '0;
        state_q      <= enable_i ? WAIT : IDLE;
      end else begin
        case (state_q)
          IDLE: if (enable_i) begin
            state_q <= WAIT;
            cnt_q   <= '0;
          end
          WAIT: begin
            if (!enable_i)                               state_q <= IDLE;
            else if (cnt_q == IW'(SCRUB_INTERVAL - 1))   state_q <= RD;
            else                                         cnt_q   <= cnt_q + 1'b1;
          end
          RD: begin
            if (!enable_i)       state_q <= IDLE;
            else if (!usr_req_i) state_q <= CHK;
          end
          CHK:     state_q <= WB;
          WB:      state_q <= WB;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i)                sec_count_q <= '0;
    else if (fsm_wr && sec_count_q != '1) sec_count_q <= sec_count_q + 1'b1;
  end

`ifdef HAMMING_SCRUB_LOG_EN
  logic [AW-1:0] last_err_addr_q;
  logic          last_err_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      last_err_addr_q  <= '0;
      last_err_valid_q <= 1'b0;
    end else if (fsm_wr) begin
      last_err_addr_q  <= scrub_addr_q;
      last_err_valid_q <= 1'b1;
    end
  end

  assign last_err_addr_o  = last_err_addr_q;
  assign last_err_valid_o = last_err_valid_q;
`endif

  assign usr_gnt_o    = usr_req_i;
  assign usr_rvalid_o = rvalid_q;
  assign usr_rdata_o  = mem_rdata_i;
  assign scrub_addr_o = scrub_addr_q;
  assign pass_done_o  = pass_done_q;
  assign sec_count_o  = sec_count_q;

endmodule

// File: tb/tb_hamming_scrubber.sv
// tb_hamming_scrubber: scoreboard bench for hamming_scrubber (N=15, DEPTH=8,
// SCRUB_INTERVAL=4, CNT_W=2 so saturation is reachable in a few errors).
module tb_hamming_scrubber;

  localparam int N     = 15;
  localparam int K     = 11;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int SI    = 4;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i, enable_i, clear_i;
  logic             usr_req_i, usr_we_i;
  logic [AW-1:0]    usr_addr_i;
  logic [N-1:0]     usr_wdata_i;
  logic             usr_gnt_o, usr_rvalid_o;
  logic [N-1:0]     usr_rdata_o;
  logic             mem_en_o, mem_we_o;
  logic [AW-1:0]    mem_addr_o;
  logic [N-1:0]     mem_wdata_o;
  logic [N-1:0]     mem_rdata_i;
  logic [AW-1:0]    scrub_addr_o;
  logic             pass_done_o;
  logic [CNT_W-1:0] sec_count_o;
`ifdef HAMMING_SCRUB_LOG_EN
  logic [AW-1:0]    last_err_addr_o;
  logic             last_err_valid_o;
`endif

  hamming_scrubber #(
    .N(N), .K(K), .DEPTH(DEPTH), .SCRUB_INTERVAL(SI), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .usr_req_i(usr_req_i), .usr_we_i(usr_we_i), .usr_addr_i(usr_addr_i),
    .usr_wdata_i(usr_wdata_i), .usr_gnt_o(usr_gnt_o), .usr_rvalid_o(usr_rvalid_o),
    .usr_rdata_o(usr_rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .scrub_addr_o(scrub_addr_o), .pass_done_o(pass_done_o),
`ifdef HAMMING_SCRUB_LOG_EN
    .last_err_addr_o(last_err_addr_o), .last_err_valid_o(last_err_valid_o),
`endif
    .sec_count_o(sec_count_o)
  );

  // Valid (15,11) codewords, hand-checked: XOR of set bit positions (bit i = position i+1) is 0.
  logic [N-1:0] init_mem [DEPTH] = '{15'h0007, 15'h0019, 15'h0181, 15'h0000,
                                     15'h0061, 15'h6001, 15'h0034, 15'h0000};

  logic [N-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i     <= ram[mem_addr_o];
    end
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
  } wr_t;

  wr_t          wr_q[$];
  logic [N-1:0] rd_q[$];
  int           checks   = 0;
  int           failures = 0;
  int           rd_cnt   = 0;
  logic [AW-1:0] exp_scrub_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: scrub writes and user read returns are popped from the queues.
  always @(negedge clk) begin
    wr_t w;
    if (mem_en_o && !usr_req_i) begin
      if (mem_we_o) begin
        if (wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_scrub_write actual=addr%0d/%h required=none", mem_addr_o, mem_wdata_o);
        end else begin
          w = wr_q.pop_front();
          chk("wb_addr", 32'(mem_addr_o), 32'(w.addr));
          chk("wb_data", 32'(mem_wdata_o), 32'(w.data));
        end
      end else begin
        chk("scrub_rd_addr", 32'(mem_addr_o), 32'(exp_scrub_addr));
        exp_scrub_addr = exp_scrub_addr + 1'b1;
        rd_cnt++;
      end
    end
    if (usr_rvalid_o) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid actual=1 required=0");
      end else begin
        chk("usr_rdata", 32'(usr_rdata_o), 32'(rd_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_scrub_read(input logic [AW-1:0] a);
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (mem_en_o && !mem_we_o && !usr_req_i && mem_addr_o == a) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wait_scrub_read_%0d actual=timeout required=read", a);
    end
  endtask

  task automatic wait_pass_done();
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (pass_done_o) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wait_pass_done actual=timeout required=pulse");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] ua [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd6};

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] <= init_mem[i];
    rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0;
    usr_req_i = 1'b0; usr_we_i = 1'b0; usr_addr_i = '0; usr_wdata_i = '0;
    repeat (3) step();

    // Reset state
    @(negedge clk);
    chk("rst_mem_en", 32'(mem_en_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_rvalid", 32'(usr_rvalid_o), 32'd0);
    chk("rst_scrub_addr", 32'(scrub_addr_o), 32'd0);
    chk("rst_pass_done", 32'(pass_done_o), 32'd0);
    chk("rst_sec_count", 32'(sec_count_o), 32'd0);
    step();
    rst_i = 1'b0; enable_i = 1'b1;

    // Clean pass: 8 reads, no writes, one pass_done
    wait_pass_done();
    chk("pass1_reads", 32'(rd_cnt), 32'd8);
    chk("pass1_sec", 32'(sec_count_o), 32'd0);
    chk("pass1_wrap_addr", 32'(scrub_addr_o), 32'd0);

    // Single error at addr 3: bit 0 flipped
    ram[3] <= 15'h0001;
    wr_q.push_back('{addr: 3'd3, data: 15'h0000});
    wait_pass_done();
    chk("pass2_reads", 32'(rd_cnt), 32'd16);
    chk("pass2_sec", 32'(sec_count_o), 32'd1);
    chk("pass2_ram3", 32'(ram[3]), 32'h0000);

    // User holds the port for 5 cycles while the FSM sits in RD (addr 2)
    wait_scrub_read(3'd1);
    repeat (6) step();
    for (int i = 0; i < 5; i++) begin
      usr_req_i = 1'b1; usr_we_i = 1'b0; usr_addr_i = ua[i];
      rd_q.push_back(init_mem[ua[i]]);
      @(negedge clk);
      chk("stall_user_addr", 32'({mem_en_o, mem_we_o, mem_addr_o}), 32'({1'b1, 1'b0, ua[i]}));
      step();
    end
    usr_req_i = 1'b0;
    ram[5] <= 15'h6081;
    @(negedge clk);
    chk("rd_after_stall", 32'({mem_en_o, mem_we_o, mem_addr_o}), 32'({1'b1, 1'b0, 3'd2}));

    // Collision: user writes addr 5 during CHK -> no write-back, no count
    wait_scrub_read(3'd5);
    step();
    usr_req_i = 1'b1; usr_we_i = 1'b1; usr_addr_i = 3'd5; usr_wdata_i = 15'h6001;
    step();
    usr_req_i = 1'b0; usr_we_i = 1'b0;
    @(negedge clk);
    chk("coll_scrub_addr", 32'(scrub_addr_o), 32'd6);
    chk("coll_sec", 32'(sec_count_o), 32'd1);

    // Errors at 6 (bit 0) and 7 (bit 10) bring the 2-bit count to 3
    ram[6] <= 15'h0035;
    ram[7] <= 15'h0400;
    wr_q.push_back('{addr: 3'd6, data: 15'h0034});
    wr_q.push_back('{addr: 3'd7, data: 15'h0000});
    wait_pass_done();
    chk("sat_reach", 32'(sec_count_o), 32'd3);
    chk("coll_ram5", 32'(ram[5]), 32'h6001);

    // One more error at 0: written back, count saturates
    ram[0] <= 15'h0006;
    wr_q.push_back('{addr: 3'd0, data: 15'h0007});
    wait_scrub_read(3'd1);
    chk("sat_hold", 32'(sec_count_o), 32'd3);

    // clear_i in the WB cycle of an error at 4 (bit 9) -> 0
    ram[4] <= 15'h0261;
    wr_q.push_back('{addr: 3'd4, data: 15'h0061});
    wait_scrub_read(3'd4);
    step();
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    @(negedge clk);
    chk("clear_wins", 32'(sec_count_o), 32'd0);

    // Reset during WB of an error at 2 (bit 1): write aborted
    ram[2] <= 15'h0183;
    wait_scrub_read(3'd2);
    step();
    step();
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_wb_we", 32'({mem_en_o, mem_we_o}), 32'd0);
    step();
    rst_i = 1'b0; enable_i = 1'b0;
    exp_scrub_addr = '0;
    @(negedge clk);
    chk("rstwb_mem_en", 32'(mem_en_o), 32'd0);
    chk("rstwb_rvalid", 32'(usr_rvalid_o), 32'd0);
    chk("rstwb_scrub_addr", 32'(scrub_addr_o), 32'd0);
    chk("rstwb_pass_done", 32'(pass_done_o), 32'd0);
    chk("rstwb_sec", 32'(sec_count_o), 32'd0);
    chk("rstwb_ram2", 32'(ram[2]), 32'h0183);

    // Restart: addr 2 still corrupted, corrected this pass
    step();
    enable_i = 1'b1;
    wr_q.push_back('{addr: 3'd2, data: 15'h0181});
    wait_pass_done();
    chk("log_pass_sec", 32'(sec_count_o), 32'd1);
`ifdef HAMMING_SCRUB_LOG_EN
    chk("last_err_addr", 32'(last_err_addr_o), 32'd2);
    chk("last_err_valid", 32'(last_err_valid_o), 32'd1);
`endif
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    enable_i = 1'b0;
    @(negedge clk);
    chk("clear_sec", 32'(sec_count_o), 32'd0);
`ifdef HAMMING_SCRUB_LOG_EN
    chk("clear_log", 32'({last_err_valid_o, last_err_addr_o}), 32'd0);
`endif

    repeat (12) step();
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
